// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 1080p60 raster defaults, counter width and FSM state encoding
package video_timing_pkg;
    localparam int CNT_W        = 12;
    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: triggered / free-running raster generator producing sync, DE and pixel coordinates
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_trig,
    input  logic             free_run,
    output logic             frame_busy,
    output logic             h_sync_out,
    output logic             v_sync_out,
    output logic             de_out,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_done
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] X0     = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] X1     = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] Y0     = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] Y1     = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
    logic             r_pending;
    logic             w_run, w_last, w_busy_nxt, w_de;

    assign w_last = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    assign w_de   = (r_h_cnt >= X0) && (r_h_cnt < X1) && (r_v_cnt >= Y0) && (r_v_cnt < Y1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;

    // A trigger landing on the last position chains the next frame just like a pending one
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE)
            w_state_nxt = (frame_trig || free_run) ? ST_RUN : ST_IDLE;
        else if (w_last)
            w_state_nxt = (r_pending || frame_trig || free_run) ? ST_RUN : ST_IDLE;
    end

    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_busy_nxt = w_run || (w_state_nxt == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_run || w_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                r_pending <= 1'b0;
        else if (!w_run || w_last) r_pending <= 1'b0;
        else if (frame_trig)       r_pending <= 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            frame_busy <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            de_out     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_busy <= w_busy_nxt;
            h_sync_out <= w_run && (r_h_cnt < HS_END);
            v_sync_out <= w_run && (r_v_cnt < VS_END);
            de_out     <= w_run && w_de;
            pix_x      <= (w_run && w_de) ? r_h_cnt - X0 : '0;
            pix_y      <= (w_run && w_de) ? r_v_cnt - Y0 : '0;
            frame_done <= w_run && w_last;
        end
endmodule
